fanout_fork_ctrl: RTL
=====================

// Module: fanout_fork_ctrl
// PURPOSE
//  Registered eager-fork controller for one stream producer broadcasting to up to NUM_OUT consumers.
//  Replaces the combinational ready-join: per-consumer accept bits let fast consumers take a token early,
//    so a slow consumer never stalls the others' valid/ready handshakes.
//  Sits between a tile's output stream and its configured fanout routes. A config write loads the enable mask.
// PARAMETERS
//  NUM_OUT   6    number of consumer ports
//  DATA_W    17   stream payload width (16b data + 1b control/stop flag)
//  CNT_W     16   width of completed-token counter
// PORTS
//  clk        in   1        clock
//  reset      in   1        asynchronous, active-high reset
//  flush      in   1        synchronous clear of in-flight token state
//  cfg_we     in   1        config write strobe
//  cfg_mask   in   NUM_OUT  consumer enable mask, bit i enables out i
//  cfg_err    out  1        1-cycle pulse: cfg_we rejected (token partially delivered)
//  in_valid   in   1        producer valid
//  in_data    in   DATA_W   producer payload
//  in_ready   out  1        token retired this cycle
//  out_valid  out  NUM_OUT  per-consumer valid
//  out_data   out  DATA_W   broadcast payload (= in_data, combinational)
//  out_ready  in   NUM_OUT  per-consumer ready
//  tok_cnt    out  CNT_W    completed input handshakes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  One clock. Reset is asynchronous and active-high.
//  Reset values: state=S_UNCFG, mask=0, done=0, tok_cnt=0, cfg_err=0.
//  Combinational outputs are therefore in_ready=0, out_valid=0.
//  Registers: mask[NUM_OUT], done[NUM_OUT] (consumer i already took the current token), 2b state.
//  out_valid[i] = run & in_valid & mask[i] & ~done[i].
//    run = state != S_UNCFG.
//  take[i] = out_valid[i] & out_ready[i].
//  complete = &(done | take | ~mask).
//  in_ready = run & complete. This holds even when in_valid=0.
//  Zero latency: a token offered with all enabled consumers ready retires in the same cycle.
//  On in_valid & in_ready:
//    - done <= 0.
//    - tok_cnt <= tok_cnt + 1, wrapping.
//  Otherwise, with in_valid=1, done <= done | take.
//  mask==0 in a run state: in_ready=1 and every token is sunk and counted. This is legal.
//  Producer must hold in_valid/in_data stable until in_ready; payload changes mid-token are undefined.
//  FSM:
//    S_UNCFG -> S_IDLE on cfg_we (mask <= cfg_mask).
//    S_IDLE (done==0) -> S_PART when in_valid & ~complete & |take.
//    S_IDLE -> S_IDLE when the token completes in one cycle, or when there is no take.
//    S_PART (done!=0) -> S_IDLE when in_valid & complete.
//  cfg_we handling:
//    - Accepted in S_UNCFG and S_IDLE, including in the same cycle as a completing handshake; new mask applies next cycle.
//    - In S_PART it is ignored: mask unchanged, cfg_err=1 for that cycle (registered, visible next cycle).
//  flush:
//    - done <= 0; state <= S_IDLE if configured, else stays S_UNCFG. mask and tok_cnt are retained.
//    - A handshake in the flush cycle is not counted.
//    - flush has priority over cfg_we, which is then ignored with no cfg_err.
//  reset asserted mid-token: all state is cleared immediately; the partially delivered token is lost.
//  Requires re-config after reset.
// STRUCTURE
//  Package fanout_pkg: typedef enum logic[1:0] {S_UNCFG,S_IDLE,S_PART} fork_state_t; NUM_OUT_DEF, DATA_W_DEF.
//  Sub-module fork_slot (one per output, generate loop): holds done[i], computes out_valid[i], take[i], and its complete term.
//  Top level holds the FSM, mask, tok_cnt, and the AND-reduce.
// TESTING
//  1 Reset, no cfg, in_valid=1 -> in_ready=0, out_valid=0 for 10 cycles; tok_cnt=0.
//  2 mask=6'b000111, all out_ready=1, 4 tokens back-to-back -> in_ready=1 every cycle, out_valid=3'b111 on [2:0], tok_cnt=4.
//  3 mask=6'b111111, out_ready[5]=0 for 3 cycles, others 1 -> out_valid[4:0] for exactly 1 cycle then 0.
//     Continued: out_valid[5] held; in_ready rises when out_ready[5]=1; state S_PART->S_IDLE.
//  4 cfg_we during S_PART -> cfg_err pulse, mask unchanged; cfg_we in S_IDLE -> new mask used next cycle.
//  5 flush while done=6'b001011 -> next cycle all enabled consumers see out_valid again for the same in_data, tok_cnt unchanged.
//  6 mask=0, 3 tokens -> in_ready=1, out_valid=0, tok_cnt=3.
//  6 Also: tok_cnt preset to 16'hFFFF via run, 1 more token -> tok_cnt=0.

Source files
------------

// File: rtl/fanout_pkg.sv
// Shared types and default sizes for the eager-fork controller.
package fanout_pkg;

  typedef enum logic [1:0] {
    S_UNCFG = 2'd0,
    S_IDLE  = 2'd1,
    S_PART  = 2'd2
  } fork_state_t;

  localparam int unsigned NUM_OUT_DEF = 6;
  localparam int unsigned DATA_W_DEF  = 17;
  localparam int unsigned CNT_W_DEF   = 16;

endpackage

// File: rtl/fork_slot.sv
// One consumer lane of the eager fork: remembers whether this consumer already
// took the current token and presents its valid/take/complete terms.
module fork_slot (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic run,
  input  logic in_valid,
  input  logic retire,
  input  logic en,
  input  logic ready,
  output logic valid,
  output logic take,
  output logic complete
);

  logic done_q;

  // Lane is satisfied once it took the token, takes it now, or is disabled.
  always_comb begin
    valid    = run & in_valid & en & ~done_q;
    take     = valid & ready;
    complete = done_q | take | ~en;
  end

  // Accept bit: cleared when the token retires or on flush, set on take.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else if (flush || retire) begin
      done_q <= 1'b0;
    end else if (in_valid) begin
      done_q <= done_q | take;
    end
  end

endmodule

// File: rtl/fanout_fork_ctrl.sv
// Registered eager-fork controller: one producer broadcast to NUM_OUT consumers,
// each consumer accepting independently so a slow one never stalls the others.
module fanout_fork_ctrl
  import fanout_pkg::*;
#(
  parameter int unsigned NUM_OUT = NUM_OUT_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               cfg_we,
  input  logic [NUM_OUT-1:0] cfg_mask,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic [NUM_OUT-1:0] out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [CNT_W-1:0]   tok_cnt
);

  fork_state_t        state_q, state_d;
  logic [NUM_OUT-1:0] mask_q, mask_d;
  logic [NUM_OUT-1:0] take;
  logic [NUM_OUT-1:0] complete_vec;
  logic               run, complete, retire, cfg_err_d;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    fork_slot u_slot (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .run      (run),
      .in_valid (in_valid),
      .retire   (retire),
      .en       (mask_q[i]),
      .ready    (out_ready[i]),
      .valid    (out_valid[i]),
      .take     (take[i]),
      .complete (complete_vec[i])
    );
  end

  // Join of all lanes; in_ready may be high with no token offered.
  always_comb begin
    run      = (state_q != S_UNCFG);
    complete = &complete_vec;
    in_ready = run & complete;
    retire   = in_valid & in_ready;
    out_data = in_data;
  end

  // Next-state: config acceptance, partial-delivery tracking, flush priority.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cfg_err_d = 1'b0;
    if (flush) begin
      state_d = run ? S_IDLE : S_UNCFG;
    end else begin
      case (state_q)
        S_UNCFG: begin
          if (cfg_we) begin
            mask_d  = cfg_mask;
            state_d = S_IDLE;
          end
        end
        S_IDLE: begin
          if (cfg_we) mask_d = cfg_mask;
          if (in_valid && !complete && (|take)) state_d = S_PART;
        end
        S_PART: begin
          // Changing the mask under a half-delivered token would corrupt it.
          if (cfg_we) cfg_err_d = 1'b1;
          if (in_valid && complete) state_d = S_IDLE;
        end
        default: state_d = S_UNCFG;
      endcase
    end
  end

  // State, mask, error pulse and completed-token counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_UNCFG;
      mask_q  <= '0;
      cfg_err <= 1'b0;
      tok_cnt <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cfg_err <= cfg_err_d;
      if (retire && !flush) tok_cnt <= tok_cnt + CNT_W'(1);
    end
  end

endmodule
